mem_access_unit: RTL and testbench

MEM-stage controller between the EX/MEM pipeline register and the MEM/WB register. It performs loads and stores through a request/acknowledge data-memory bus, with sub-word lane steering and sign/zero extension. It stalls the pipeline while an access is outstanding and produces the RegWrite, WriteAddress and WriteData values captured by MEM/WB. It also detects misaligned accesses and bus timeouts.

---
 rtl/processor_defs.sv | 20 ++
 rtl/mem_lane_format.sv | 63 ++++++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/processor_defs.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states
// and the default bus timeout.
package processor_defs;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_BUSY = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_lane_format.sv
// Combinational lane steering: byte enables, store-data replication and
// load extract/extend for little-endian sub-word accesses.
module mem_lane_format
  import processor_defs::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_rep,
  output logic [31:0] load_fmt
);

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;
  logic        [31:0] byte_zx;
  logic        [31:0] half_zx;

  // Pick the addressed lanes and form both extensions of each
  always_comb begin
    ld_byte = '0;
    case (addr_lo)
      2'd0:    ld_byte = load_word[7:0];
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      default: ld_byte = load_word[31:24];
    endcase
    ld_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    byte_sx = ld_byte;
    half_sx = ld_half;
    byte_zx = {24'h000000, ld_byte};
    half_zx = {16'h0000, ld_half};
  end

  // Size-dependent enables, replication and result selection; reserved size acts as word
  always_comb begin
    byte_en   = 4'b1111;
    store_rep = store_data;
    load_fmt  = load_word;
    case (mem_size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        store_rep = {4{store_data[7:0]}};
        load_fmt  = mem_signed ? byte_sx : byte_zx;
      end
      SIZE_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{store_data[15:0]}};
        load_fmt  = mem_signed ? half_sx : half_zx;
      end
      default: begin
        byte_en   = 4'b1111;
        store_rep = store_data;
        load_fmt  = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: drives the request/ack data bus, stalls the pipeline
// while an access is outstanding and forms the MEM/WB write-back values.
module mem_access_unit
  import processor_defs::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic [4:0]  WriteAddress,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  output logic        DBusReq,
  output logic        DBusWe,
  output logic [31:0] DBusAddr,
  output logic [31:0] DBusWData,
  output logic [3:0]  DBusBe,
  input  logic        DBusAck,
  input  logic [31:0] DBusRData,
  output logic        Stall,
  output logic        REGWRITE_O,
  output logic [4:0]  WRITEADDRESS_O,
  output logic [31:0] WRITEDATA_O,
  output logic        AddrExc,
  output logic        BusErr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ma_state_e        state_q;
  ma_state_e        state_d;
  logic [CNT_W-1:0] cnt_p1;
  logic [31:0]      rdata_p1;
  logic             err_p1;

  logic        mem_op_raw;
  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_fmt_c;

  assign mem_op_raw = MemRead | MemWrite;
  assign is_half    = (MemSize == SIZE_HALF);
  assign is_word    = MemSize[1];
  assign AddrExc    = mem_op_raw & ((is_half & ALUResult[0]) |
                                    (is_word & (ALUResult[1:0] != 2'b00)));
  assign mem_op     = mem_op_raw & ~AddrExc;

  mem_lane_format u_fmt (
    .addr_lo    (ALUResult[1:0]),
    .mem_size   (MemSize),
    .mem_signed (MemSigned),
    .store_data (StoreData),
    .load_word  (rdata_p1),
    .byte_en    (be_c),
    .store_rep  (wdata_c),
    .load_fmt   (load_fmt_c)
  );

  // State register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= MA_IDLE;
    else          state_q <= state_d;
  end

  // Next state, stall and error pulse
  always_comb begin
    state_d = state_q;
    Stall   = 1'b0;
    BusErr  = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (mem_op) begin
          state_d = MA_BUSY;
          Stall   = 1'b1;
        end
      end
      MA_BUSY: begin
        Stall = 1'b1;
        if (DBusAck || (cnt_p1 == CNT_LAST)) state_d = MA_DONE;
      end
      MA_DONE: begin
        BusErr  = err_p1;
        state_d = MA_IDLE;
      end
      default: state_d = MA_IDLE;
    endcase
  end

  // Bus registers, timeout counter, captured read data and error flag; ack wins over timeout
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DBusReq   <= 1'b0;
      DBusWe    <= 1'b0;
      DBusAddr  <= '0;
      DBusWData <= '0;
      DBusBe    <= '0;
      cnt_p1    <= '0;
      rdata_p1  <= '0;
      err_p1    <= 1'b0;
    end else begin
      case (state_q)
        MA_IDLE: begin
          if (mem_op) begin
            DBusReq   <= 1'b1;
            DBusWe    <= ~MemRead;
            DBusAddr  <= {ALUResult[31:2], 2'b00};
            DBusWData <= wdata_c;
            DBusBe    <= be_c;
            cnt_p1    <= '0;
          end
        end
        MA_BUSY: begin
          if (DBusAck) begin
            DBusReq  <= 1'b0;
            rdata_p1 <= DBusRData;
          end else if (cnt_p1 == CNT_LAST) begin
            DBusReq <= 1'b0;
            err_p1  <= 1'b1;
          end else begin
            cnt_p1 <= cnt_p1 + 1'b1;
          end
        end
        MA_DONE: err_p1 <= 1'b0;
        default: ;
      endcase
    end
  end

  assign WRITEDATA_O    = (MemToReg & MemRead) ? load_fmt_c : ALUResult;
  assign REGWRITE_O     = RegWrite & ~Stall & ~AddrExc & ~BusErr;
  assign WRITEADDRESS_O = WriteAddress;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: word/byte/half loads and stores,
// misalignment, bus timeout and reset during an outstanding access.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        MemRead, MemWrite, MemSigned, MemToReg, RegWrite;
  logic [1:0]  MemSize;
  logic [4:0]  WriteAddress;
  logic [31:0] ALUResult, StoreData;
  logic        DBusReq, DBusWe, DBusAck;
  logic [31:0] DBusAddr, DBusWData, DBusRData;
  logic [3:0]  DBusBe;
  logic        Stall, REGWRITE_O, AddrExc, BusErr;
  logic [4:0]  WRITEADDRESS_O;
  logic [31:0] WRITEDATA_O;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk            (clk),
    .Reset_n        (Reset_n),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .MemSize        (MemSize),
    .MemSigned      (MemSigned),
    .MemToReg       (MemToReg),
    .RegWrite       (RegWrite),
    .WriteAddress   (WriteAddress),
    .ALUResult      (ALUResult),
    .StoreData      (StoreData),
    .DBusReq        (DBusReq),
    .DBusWe         (DBusWe),
    .DBusAddr       (DBusAddr),
    .DBusWData      (DBusWData),
    .DBusBe         (DBusBe),
    .DBusAck        (DBusAck),
    .DBusRData      (DBusRData),
    .Stall          (Stall),
    .REGWRITE_O     (REGWRITE_O),
    .WRITEADDRESS_O (WRITEADDRESS_O),
    .WRITEDATA_O    (WRITEDATA_O),
    .AddrExc        (AddrExc),
    .BusErr         (BusErr)
  );

  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'd2; MemSigned = 1'b0;
    MemToReg = 1'b0; RegWrite = 1'b0; WriteAddress = 5'd0;
    ALUResult = 32'h0; StoreData = 32'h0; DBusAck = 1'b0; DBusRData = 32'h0;
  endtask

  // Applies one instruction in IDLE and plays the memory side: ack in the
  // ack_at-th request cycle (0 = never). Returns what was seen on the bus and
  // the write-back values in the first unstalled cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic m2r, input logic rw,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int ack_at,
                            output int n_stall, output int n_req,
                            output logic [31:0] wd, output logic rwo, output logic berr,
                            output logic aexc, output logic [31:0] baddr,
                            output logic [3:0] bbe, output logic [31:0] bwd,
                            output logic bwe, output logic hung);
    n_stall = 0; n_req = 0; wd = '0; rwo = 1'b0; berr = 1'b0; aexc = 1'b0;
    baddr = '0; bbe = '0; bwd = '0; bwe = 1'b0; hung = 1'b1;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg; MemToReg = m2r;
    RegWrite = rw; WriteAddress = 5'd7; ALUResult = addr; StoreData = sdata;
    DBusAck = 1'b0; DBusRData = 32'h5A5A5A5A;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (DBusReq && (n_req + 1 == ack_at)) begin
          DBusAck = 1'b1; DBusRData = rdata;
        end else begin
          DBusAck = 1'b0; DBusRData = 32'h5A5A5A5A;
        end
      end
      @(negedge clk);
      if (DBusReq) begin
        n_req++;
        baddr = DBusAddr; bbe = DBusBe; bwd = DBusWData; bwe = DBusWe;
      end
      if (Stall) n_stall++;
      else begin
        wd = WRITEDATA_O; rwo = REGWRITE_O; berr = BusErr; aexc = AddrExc;
        hung = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (DBusReq !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b want 0", DBusReq); end
    n_checks++; if (DBusWe !== 1'b0) begin n_fails++; $display("FAIL reset_we: got %b want 0", DBusWe); end
    n_checks++; if (DBusAddr !== 32'h0) begin n_fails++; $display("FAIL reset_addr: got %h want 0", DBusAddr); end
    n_checks++; if (DBusWData !== 32'h0) begin n_fails++; $display("FAIL reset_wdata: got %h want 0", DBusWData); end
    n_checks++; if (DBusBe !== 4'h0) begin n_fails++; $display("FAIL reset_be: got %h want 0", DBusBe); end
    n_checks++; if (Stall !== 1'b0) begin n_fails++; $display("FAIL reset_stall: got %b want 0", Stall); end
    n_checks++; if (BusErr !== 1'b0) begin n_fails++; $display("FAIL reset_buserr: got %b want 0", BusErr); end
    Reset_n = 1'b1;
  endtask

  task automatic test_word_load();
    int ns, nr; logic [31:0] wd, ba, bw; logic rwo, be_, ax, we, hg; logic [3:0] bb;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 2,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (hg !== 1'b0) begin n_fails++; $display("FAIL wload_done: stall never released"); end
    n_checks++; if (ns != 3) begin n_fails++; $display("FAIL wload_stall_cycles: got %0d want 3", ns); end
    n_checks++; if (nr != 2) begin n_fails++; $display("FAIL wload_req_cycles: got %0d want 2", nr); end
    n_checks++; if (wd !== 32'hDEADBEEF) begin n_fails++; $display("FAIL wload_data: got %h want deadbeef", wd); end
    n_checks++; if (rwo !== 1'b1) begin n_fails++; $display("FAIL wload_regwrite: got %b want 1", rwo); end
    n_checks++; if (ba !== 32'h100) begin n_fails++; $display("FAIL wload_addr: got %h want 100", ba); end
    n_checks++; if (bb !== 4'hF) begin n_fails++; $display("FAIL wload_be: got %h want f", bb); end
    n_checks++; if (we !== 1'b0) begin n_fails++; $display("FAIL wload_we: got %b want 0", we); end
  endtask

  task automatic test_subword_load();
    int ns, nr; logic [31:0] wd, ba, bw; logic rwo, be_, ax, we, hg; logic [3:0] bb;
    run_access(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (wd !== 32'hFFFFFF80) begin n_fails++; $display("FAIL lb_signed: got %h want ffffff80", wd); end
    n_checks++; if (bb !== 4'b1000) begin n_fails++; $display("FAIL lb_be: got %b want 1000", bb); end
    n_checks++; if (ba !== 32'h100) begin n_fails++; $display("FAIL lb_addr: got %h want 100", ba); end
    run_access(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (wd !== 32'h00000080) begin n_fails++; $display("FAIL lbu_unsigned: got %h want 00000080", wd); end
    n_checks++; if (ns != 2) begin n_fails++; $display("FAIL lbu_stall_cycles: got %0d want 2", ns); end
    run_access(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 32'h102, 32'h0, 32'h80017FFF, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (wd !== 32'hFFFF8001) begin n_fails++; $display("FAIL lh_signed: got %h want ffff8001", wd); end
    n_checks++; if (bb !== 4'b1100) begin n_fails++; $display("FAIL lh_be: got %b want 1100", bb); end
    run_access(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'h80017FFF, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (wd !== 32'h00007FFF) begin n_fails++; $display("FAIL lhu_low: got %h want 00007fff", wd); end
  endtask

  task automatic test_store();
    int ns, nr; logic [31:0] wd, ba, bw; logic rwo, be_, ax, we, hg; logic [3:0] bb;
    run_access(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (we !== 1'b1) begin n_fails++; $display("FAIL sh_we: got %b want 1", we); end
    n_checks++; if (bb !== 4'b1100) begin n_fails++; $display("FAIL sh_be: got %b want 1100", bb); end
    n_checks++; if (bw !== 32'hABCDABCD) begin n_fails++; $display("FAIL sh_wdata: got %h want abcdabcd", bw); end
    n_checks++; if (ba !== 32'h200) begin n_fails++; $display("FAIL sh_addr: got %h want 200", ba); end
    n_checks++; if (rwo !== 1'b0) begin n_fails++; $display("FAIL sh_regwrite: got %b want 0", rwo); end
    run_access(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h201, 32'h000000A5, 32'h0, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (bb !== 4'b0010) begin n_fails++; $display("FAIL sb_be: got %b want 0010", bb); end
    n_checks++; if (bw !== 32'hA5A5A5A5) begin n_fails++; $display("FAIL sb_wdata: got %h want a5a5a5a5", bw); end
  endtask

  task automatic test_misaligned();
    int ns, nr; logic [31:0] wd, ba, bw; logic rwo, be_, ax, we, hg; logic [3:0] bb;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 32'h101, 32'h0, 32'h0, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (ax !== 1'b1) begin n_fails++; $display("FAIL mis_addrexc: got %b want 1", ax); end
    n_checks++; if (ns != 0) begin n_fails++; $display("FAIL mis_stall: got %0d stall cycles want 0", ns); end
    n_checks++; if (nr != 0) begin n_fails++; $display("FAIL mis_req: got %0d req cycles want 0", nr); end
    n_checks++; if (rwo !== 1'b0) begin n_fails++; $display("FAIL mis_regwrite: got %b want 0", rwo); end
    @(negedge clk);
    n_checks++; if (DBusReq !== 1'b0) begin n_fails++; $display("FAIL mis_req_after: got %b want 0", DBusReq); end
  endtask

  task automatic test_timeout();
    int ns, nr; logic [31:0] wd, ba, bw; logic rwo, be_, ax, we, hg; logic [3:0] bb;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 32'h0, 0,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (hg !== 1'b0) begin n_fails++; $display("FAIL to_done: stall never released"); end
    n_checks++; if (nr != 16) begin n_fails++; $display("FAIL to_req_cycles: got %0d want 16", nr); end
    n_checks++; if (ns != 17) begin n_fails++; $display("FAIL to_stall_cycles: got %0d want 17", ns); end
    n_checks++; if (be_ !== 1'b1) begin n_fails++; $display("FAIL to_buserr: got %b want 1", be_); end
    n_checks++; if (rwo !== 1'b0) begin n_fails++; $display("FAIL to_regwrite: got %b want 0", rwo); end
    @(negedge clk);
    n_checks++; if (BusErr !== 1'b0) begin n_fails++; $display("FAIL to_pulse_width: got %b want 0", BusErr); end
    n_checks++; if (Stall !== 1'b0) begin n_fails++; $display("FAIL to_idle_stall: got %b want 0", Stall); end
  endtask

  task automatic test_reset_mid_access();
    int ns, nr; logic [31:0] wd, ba, bw; logic rwo, be_, ax, we, hg; logic [3:0] bb;
    @(posedge clk); #1;
    MemRead = 1'b1; MemSize = 2'd2; MemToReg = 1'b1; RegWrite = 1'b1; ALUResult = 32'h400;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (DBusReq !== 1'b1) begin n_fails++; $display("FAIL rst_mid_busy: got %b want 1", DBusReq); end
    #1 Reset_n = 1'b0;
    #1;
    n_checks++; if (DBusReq !== 1'b0) begin n_fails++; $display("FAIL rst_mid_req: got %b want 0", DBusReq); end
    idle_inputs();
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fails++; $display("FAIL rst_mid_stall: got %b want 0", Stall); end
    #1 Reset_n = 1'b1;
    run_access(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 32'h0, 1,
               ns, nr, wd, rwo, be_, ax, ba, bb, bw, we, hg);
    n_checks++; if (ns != 0) begin n_fails++; $display("FAIL alu_stall: got %0d want 0", ns); end
    n_checks++; if (wd !== 32'h55) begin n_fails++; $display("FAIL alu_data: got %h want 55", wd); end
    n_checks++; if (rwo !== 1'b1) begin n_fails++; $display("FAIL alu_regwrite: got %b want 1", rwo); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
